// File: rtl/fx_ga_itc.sv
// fx_ga_itc: parametrised PC-FX gate-array interrupt controller.
// Ports: CLK/RES/CE, 16-bit I/O bus (CSn RDn WRn ADDR DI DO),
//   SRC requests, IACK, registered CINT/CLVL/CSRC to the V810.
module fx_ga_itc #(
  parameter  int NSRC = 7,
  parameter  int LVLW = 3,
  localparam int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            CE,
  input  logic            CSn,
  input  logic            RDn,
  input  logic            WRn,
  input  logic [2:0]      ADDR,
  input  logic [15:0]     DI,
  output logic [15:0]     DO,
  input  logic [NSRC-1:0] SRC,
  input  logic            IACK,
  output logic            CINT,
  output logic [LVLW-1:0] CLVL,
  output logic [IW-1:0]   CSRC
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] imr;
  logic [NSRC-1:0] mode;
  logic [LVLW-1:0] ilr [NSRC];

  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] set;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] mode_n;
  logic [NSRC-1:0] imr_n;
  logic [NSRC-1:0] pend_n;
  logic [LVLW-1:0] ilr_n [NSRC];
  logic [LVLW-1:0] best_l;
  logic [IW-1:0]   best_i;
  logic            wr;

  // Bits beyond NSRC/LVLW are architecturally ignored.
  logic unused_di;
  assign unused_di = ^DI;

  assign wr = ~CSn & ~WRn;

  // Level sources follow src_q; edge sources use the latch.
  assign pend = (mode & pend_q) | (~mode & src_q);
  assign set  = SRC & ~src_q;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      elig[i] = pend[i] & ~imr[i] & (ilr[i] != '0);
    end
  end

  // Strict '>' keeps the lowest index on equal levels.
  always_comb begin
    best_l = '0;
    best_i = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (elig[i] && ilr[i] > best_l) begin
        best_l = ilr[i];
        best_i = IW'(i);
      end
    end
  end

  always_comb begin
    mode_n = mode;
    imr_n  = imr;
    ilr_n  = ilr;
    clr    = '0;
    if (wr) begin
      case (ADDR)
        3'd0: clr = DI[NSRC-1:0];
        3'd1: imr_n = DI[NSRC-1:0];
        3'd2: begin
          mode_n = DI[NSRC-1:0];
          clr    = mode & ~DI[NSRC-1:0];
        end
        default: begin
          for (int i = 0; i < NSRC; i++) begin
            if (ADDR[2] && ADDR[1:0] == 2'(i / 4)) begin
              ilr_n[i] = DI[4*(i%4) +: LVLW];
            end
          end
        end
      endcase
    end
    for (int i = 0; i < NSRC; i++) begin
      if (IACK && CINT && CSRC == IW'(i) && mode[i]) begin
        clr[i] = 1'b1;
      end
    end
    // Set beats clear; latch only lives in edge mode.
    pend_n = ((pend_q & ~clr) | set) & mode_n;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      src_q  <= '0;
      pend_q <= '0;
      mode   <= '0;
      imr    <= '1;
      for (int i = 0; i < NSRC; i++) begin
        ilr[i] <= LVLW'((1 << LVLW) - 1 - (i % 4));
      end
      CINT <= 1'b0;
      CLVL <= '0;
      CSRC <= '0;
    end else if (CE) begin
      src_q  <= SRC;
      pend_q <= pend_n;
      mode   <= mode_n;
      imr    <= imr_n;
      ilr    <= ilr_n;
      CINT   <= |elig;
      CLVL   <= best_l;
      CSRC   <= best_i;
    end
  end

  always_comb begin
    DO = '0;
    if (~CSn && ~RDn) begin
      case (ADDR)
        3'd0: DO[NSRC-1:0] = pend;
        3'd1: DO[NSRC-1:0] = imr;
        3'd2: DO[NSRC-1:0] = mode;
        default: begin
          for (int i = 0; i < NSRC; i++) begin
            if (ADDR[2] && ADDR[1:0] == 2'(i / 4)) begin
              DO[4*(i%4) +: LVLW] = ilr[i];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_ga_itc.sv
// tb_fx_ga_itc: directed + randomized bench for fx_ga_itc
// against a behavioural model of the interrupt controller.
module tb_fx_ga_itc;

  logic        CLK = 1'b0;
  logic        RES, CE, CSn, RDn, WRn, IACK;
  logic [2:0]  ADDR;
  logic [15:0] DI, DO, DO2;
  logic [6:0]  SRC;
  logic [11:0] SRC2;
  logic        CINT, CINT2;
  logic [2:0]  CLVL, CSRC;
  logic [3:0]  CLVL2, CSRC2;

  int npass = 0;
  int ntot  = 0;

  always #5 CLK = ~CLK;

  fx_ga_itc #(.NSRC(7), .LVLW(3)) u_dut (
    .CLK(CLK), .RES(RES), .CE(CE), .CSn(CSn), .RDn(RDn),
    .WRn(WRn), .ADDR(ADDR), .DI(DI), .DO(DO), .SRC(SRC),
    .IACK(IACK), .CINT(CINT), .CLVL(CLVL), .CSRC(CSRC)
  );

  fx_ga_itc #(.NSRC(12), .LVLW(4)) u_dut2 (
    .CLK(CLK), .RES(RES), .CE(CE), .CSn(CSn), .RDn(RDn),
    .WRn(WRn), .ADDR(ADDR), .DI(DI), .DO(DO2), .SRC(SRC2),
    .IACK(IACK), .CINT(CINT2), .CLVL(CLVL2), .CSRC(CSRC2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model (7 sources, 3-bit levels).
  bit m_srcq [7];
  bit m_pend [7];
  bit m_imr  [7];
  bit m_mode [7];
  int m_ilr  [7];
  int m_cint, m_clvl, m_csrc;

  function automatic void m_reset();
    for (int i = 0; i < 7; i++) begin
      m_srcq[i] = 0; m_pend[i] = 0; m_imr[i] = 1; m_mode[i] = 0;
      m_ilr[i] = 7 - (i % 4);
    end
    m_cint = 0; m_clvl = 0; m_csrc = 0;
  endfunction

  function automatic int m_pe(int i);
    return m_mode[i] ? int'(m_pend[i]) : int'(m_srcq[i]);
  endfunction

  function automatic int m_read(int a);
    int r = 0;
    for (int i = 0; i < 7; i++) begin
      if (a == 0) r += m_pe(i) * (1 << i);
      if (a == 1) r += int'(m_imr[i]) * (1 << i);
      if (a == 2) r += int'(m_mode[i]) * (1 << i);
    end
    if (a >= 4)
      for (int k = 0; k < 4; k++)
        if (4 * (a - 4) + k < 7) r += m_ilr[4*(a-4)+k] * (1 << (4*k));
    return r;
  endfunction

  task automatic m_step();
    int best, bi, a;
    bit clr [7];
    bit nmode [7];
    if (!CE) return;
    best = 0;
    bi = 0;
    for (int i = 0; i < 7; i++)
      if (m_pe(i) == 1 && !m_imr[i] && m_ilr[i] > best) best = m_ilr[i];
    for (int i = 6; i >= 0; i--)
      if (best > 0 && m_pe(i) == 1 && !m_imr[i] && m_ilr[i] == best) bi = i;
    nmode = m_mode;
    for (int i = 0; i < 7; i++) clr[i] = 0;
    a = int'(ADDR);
    if (!CSn && !WRn) begin
      for (int i = 0; i < 7; i++) begin
        if (a == 0) clr[i] = DI[i];
        if (a == 1) m_imr[i] = DI[i];
        if (a == 2) begin
          nmode[i] = DI[i];
          if (m_mode[i] && !DI[i]) clr[i] = 1;
        end
      end
      if (a >= 4)
        for (int k = 0; k < 4; k++)
          if (4 * (a - 4) + k < 7) m_ilr[4*(a-4)+k] = (int'(DI) >> (4*k)) & 7;
    end
    if (IACK && m_cint == 1 && m_mode[m_csrc]) clr[m_csrc] = 1;
    for (int i = 0; i < 7; i++) begin
      if (!nmode[i]) m_pend[i] = 0;
      else if (SRC[i] && !m_srcq[i]) m_pend[i] = 1;
      else if (clr[i]) m_pend[i] = 0;
      m_srcq[i] = SRC[i];
    end
    m_mode = nmode;
    m_cint = (best > 0) ? 1 : 0;
    m_clvl = best;
    m_csrc = (best > 0) ? bi : 0;
  endtask

  task automatic tick();
    #1;
    if (!CSn && !RDn) chk("do", int'(DO), m_read(int'(ADDR)));
    m_step();
    @(posedge CLK);
    #1;
    chk("cint", int'(CINT), m_cint);
    chk("clvl", int'(CLVL), m_clvl);
    chk("csrc", int'(CSRC), m_csrc);
  endtask

  task automatic wr(input int a, input int d);
    CSn = 0; WRn = 0; ADDR = 3'(a); DI = 16'(d);
    tick();
    CSn = 1; WRn = 1;
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    CSn = 0; RDn = 0; ADDR = 3'(a);
    #1;
    chk(tag, int'(DO), exp);
    tick();
    CSn = 1; RDn = 1;
  endtask

  task automatic do_reset();
    RES = 1;
    #2;
    m_reset();
    chk("rst_cint", int'(CINT), 0);
    chk("rst_clvl", int'(CLVL), 0);
    chk("rst_csrc", int'(CSRC), 0);
    RES = 0;
  endtask

  initial begin
    RES = 0; CE = 1; CSn = 1; RDn = 1; WRn = 1; IACK = 0;
    ADDR = '0; DI = '0; SRC = '0; SRC2 = '0;
    m_reset();
    #1;
    do_reset();
    tick();
    rd("rst_imr", 1, 16'h007F);
    rd("rst_ilr4", 4, 16'h4567);
    rd("rst_ilr5", 5, 16'h0567);

    // Level mode
    wr(1, 0);
    SRC = 7'h04;
    tick(); tick();
    chk("lvl_cint", int'(CINT), 1);
    chk("lvl_clvl", int'(CLVL), 5);
    chk("lvl_csrc", int'(CSRC), 2);
    SRC = 7'h00;
    tick(); tick();
    chk("lvl_drop", int'(CINT), 0);

    // Edge latch and W1C
    wr(2, 1);
    SRC = 7'h01;
    tick();
    SRC = 7'h00;
    tick();
    chk("edg_cint", int'(CINT), 1);
    chk("edg_clvl", int'(CLVL), 7);
    chk("edg_csrc", int'(CSRC), 0);
    tick(); tick();
    chk("edg_hold", int'(CINT), 1);
    wr(0, 1);
    tick();
    chk("w1c_cint", int'(CINT), 0);

    // Priority and tie-break
    wr(2, 0);
    wr(4, 16'h0333);
    SRC = 7'h06;
    tick(); tick();
    chk("tie_csrc", int'(CSRC), 1);
    chk("tie_clvl", int'(CLVL), 3);
    wr(4, 16'h0633);
    tick();
    chk("pri_csrc", int'(CSRC), 2);
    chk("pri_clvl", int'(CLVL), 6);
    wr(4, 16'h0033);
    tick();
    chk("lv0_csrc", int'(CSRC), 1);

    // IACK racing a new edge
    wr(4, 16'h4567);
    wr(2, 16'h0008);
    SRC = 7'h00; tick();
    SRC = 7'h08; tick();
    SRC = 7'h00; tick();
    chk("ia_pre", int'(CSRC), 3);
    IACK = 1; SRC = 7'h08; tick();
    IACK = 0; tick();
    chk("ia_race_cint", int'(CINT), 1);
    chk("ia_race_csrc", int'(CSRC), 3);
    rd("ia_isr", 0, 16'h0008);
    IACK = 1; tick();
    IACK = 0; tick();
    chk("ia_clr_cint", int'(CINT), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      CE = ($urandom % 10) != 0;
      if ($urandom % 3 == 0) SRC = 7'($urandom);
      IACK = ($urandom % 6) == 0;
      case ($urandom % 6)
        0: begin
          CSn = 0; WRn = 0; ADDR = 3'($urandom);
          DI = 16'($urandom);
          if (ADDR == 3'd1) DI = DI & 16'($urandom);
        end
        1: begin
          CSn = 0; RDn = 0; ADDR = 3'($urandom);
        end
        default: ;
      endcase
      tick();
      CSn = 1; RDn = 1; WRn = 1; IACK = 0;
      if ($urandom % 400 == 0) do_reset();
    end

    // Wide configuration: 12 sources, 4-bit levels
    CE = 1; SRC = '0; SRC2 = '0;
    do_reset();
    CSn = 0; RDn = 0; ADDR = 3'd6;
    #1;
    chk("w_rst_ilr6", int'(DO2), 16'hCDEF);
    CSn = 1; RDn = 1;
    wr(1, 0);
    wr(4, 16'h1111);
    wr(5, 16'h1111);
    wr(6, 16'hF000);
    SRC2 = 12'hFFF;
    tick(); tick();
    chk("w_cint", int'(CINT2), 1);
    chk("w_csrc", int'(CSRC2), 11);
    chk("w_clvl", int'(CLVL2), 15);
    CSn = 0; RDn = 0; ADDR = 3'd0;
    #1;
    chk("w_isr", int'(DO2), 16'h0FFF);
    ADDR = 3'd7;
    #1;
    chk("w_ilr7", int'(DO2), 0);
    CSn = 1; RDn = 1;
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
